// File: rtl/cplx_integrate_dump_pkg.sv
// Shared types and arithmetic helpers for the complex integrate-and-dump stage.
// Helpers work on MAX_W-bit containers so any lane width up to MAX_W-2 can use them.
package cplx_integrate_dump_pkg;

    localparam int MAX_W = 64;

    typedef enum logic {IDLE, ACCUM} state_t;

    // Sign-extend the low w bits of x to the full container width.
    function automatic logic [MAX_W-1:0] sext(input logic [MAX_W-1:0] x, input int w);
        logic signed [MAX_W-1:0] t;
        t = $signed(x << (MAX_W - w));
        return t >>> (MAX_W - w);
    endfunction

    // a and b are w-bit values already sign-extended; clamps to the w-bit signed range.
    function automatic logic [MAX_W-1:0] sat_add(input logic [MAX_W-1:0] a,
                                                 input logic [MAX_W-1:0] b,
                                                 input int w);
        logic signed [MAX_W-1:0] s;
        logic signed [MAX_W-1:0] hi;
        logic signed [MAX_W-1:0] lo;
        s  = $signed(a) + $signed(b);
        hi = $signed((MAX_W'(1) << (w - 1)) - MAX_W'(1));
        lo = ~hi;
        if (s > hi) return hi;
        if (s < lo) return lo;
        return s;
    endfunction

endpackage

// File: rtl/cplx_acc_lane.sv
// One signed accumulator lane (I or Q) with clear/load/add controls.
// Saturating accumulation is built only when CPLX_INTEGRATE_DUMP_SAT_EN is defined.
module cplx_acc_lane
    import cplx_integrate_dump_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int ACC_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clr,
    input  logic                 load,
    input  logic                 add,
    input  logic [WIDTH-1:0]     sample,
    output logic [ACC_WIDTH-1:0] sum
);

    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH-1:0] base;

    // load starts a frame from zero; sum is also the dump value on the final sample
    assign base = load ? '0 : acc;

`ifdef CPLX_INTEGRATE_DUMP_SAT_EN
    assign sum = ACC_WIDTH'(sat_add(sext(MAX_W'(base), ACC_WIDTH),
                                    sext(MAX_W'(sample), WIDTH), ACC_WIDTH));
`else
    assign sum = base + ACC_WIDTH'(sext(MAX_W'(sample), WIDTH));
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)         acc <= '0;
        else if (clr)         acc <= '0;
        else if (load || add) acc <= sum;
    end

endmodule

// File: rtl/cplx_integrate_dump.sv
// Complex integrate-and-dump: sums frames of I/Q samples, one AXI-stream beat per frame.
// Optional macro CPLX_INTEGRATE_DUMP_SAT_EN selects saturating instead of wrapping sums.
module cplx_integrate_dump
    import cplx_integrate_dump_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int ACC_WIDTH = 32,
    parameter int LEN_WIDTH = 12
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [LEN_WIDTH-1:0]   len,
    input  logic [2*WIDTH-1:0]     i_tdata,
    input  logic                   i_tlast,
    input  logic                   i_tvalid,
    output logic                   i_tready,
    output logic [2*ACC_WIDTH-1:0] o_tdata,
    output logic                   o_tlast,
    output logic                   o_tvalid,
    input  logic                   o_tready,
    output logic [LEN_WIDTH-1:0]   o_count
);

    localparam int NUM_LANES = 2;

    state_t                               state;
    logic [LEN_WIDTH-1:0]                 frame_len;
    logic [LEN_WIDTH-1:0]                 cnt;
    logic [LEN_WIDTH-1:0]                 cnt_nxt;
    logic [LEN_WIDTH-1:0]                 len_eff;
    logic                                 accept;
    logic                                 out_acc;
    logic                                 last_hit;
    logic                                 dump;
    logic [NUM_LANES-1:0][WIDTH-1:0]      lane_in;
    logic [NUM_LANES-1:0][ACC_WIDTH-1:0]  lane_sum;

    // lane 1 is I (upper half), lane 0 is Q, matching both bus layouts
    assign lane_in  = i_tdata;
    assign i_tready = !o_tvalid || o_tready;
    assign accept   = i_tvalid && i_tready;
    assign out_acc  = o_tvalid && o_tready;
    assign len_eff  = (len == '0) ? LEN_WIDTH'(1) : len;
    assign cnt_nxt  = cnt + LEN_WIDTH'(1);

    always_comb begin
        last_hit = 1'b0;
        if (state == IDLE) last_hit = (len_eff == LEN_WIDTH'(1));
        else               last_hit = (cnt_nxt == frame_len);
        dump = accept && (last_hit || i_tlast);
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        cplx_acc_lane #(
            .WIDTH     (WIDTH),
            .ACC_WIDTH (ACC_WIDTH)
        ) u_lane (
            .clk     (clk),
            .reset_n (reset_n),
            .clr     (dump),
            .load    (accept && (state == IDLE)),
            .add     (accept && (state == ACCUM)),
            .sample  (lane_in[g]),
            .sum     (lane_sum[g])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            frame_len <= LEN_WIDTH'(1);
            cnt       <= '0;
            o_tdata   <= '0;
            o_count   <= '0;
            o_tvalid  <= 1'b0;
            o_tlast   <= 1'b0;
        end else begin
            if (out_acc) begin
                o_tvalid <= 1'b0;
                o_tlast  <= 1'b0;
            end
            if (accept) begin
                case (state)
                    IDLE: begin
                        frame_len <= len_eff;
                        if (dump) begin
                            cnt <= '0;
                        end else begin
                            cnt   <= LEN_WIDTH'(1);
                            state <= ACCUM;
                        end
                    end
                    ACCUM: begin
                        if (dump) begin
                            cnt   <= '0;
                            state <= IDLE;
                        end else begin
                            cnt <= cnt_nxt;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
            // a dump on the same edge as an output accept reloads and keeps valid high
            if (dump) begin
                o_tdata  <= lane_sum;
                o_count  <= cnt_nxt;
                o_tvalid <= 1'b1;
                o_tlast  <= 1'b1;
            end
        end
    end

endmodule
